// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the polyphase FIR control path: sequencer states and
// default timing constants used by both the sequencer and the FIR datapath.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StMac,
        StDump
    } seq_state_e;

    localparam int unsigned DefaultNph = 4;
    localparam int unsigned DefaultDiv = 8;
    localparam int unsigned DefaultPhW = 2;

endpackage

// File: rtl/sample_strobe_gen.sv
// Sample-rate strobe and half-rate enable generator: internal divider or a
// one-cycle-delayed external strobe, both gated by the sequencer's run state.
module sample_strobe_gen
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned DIV      = DefaultDiv,
    parameter bit          EXT_SYNC = 1'b0
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic start,
    input  logic en,
    input  logic ext_strobe,
    output logic sam_clk_en,
    output logic sys_clk2_en
);

    localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            sam_q, sam_d;
    logic            clk2_q, clk2_d;

    always_comb begin
        div_cnt_d = '0;
        if (en && (div_cnt_q != CntMax)) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (EXT_SYNC) begin
            sam_d = en && ext_strobe;
        end else begin
            sam_d = en && (div_cnt_q == CntMax);
        end

        // Half-rate phase is anchored so the first active cycle reads 1.
        clk2_d = 1'b0;
        if (start) begin
            clk2_d = 1'b1;
        end else if (en) begin
            clk2_d = ~clk2_q;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            sam_q     <= 1'b0;
            clk2_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sam_q     <= sam_d;
            clk2_q    <= clk2_d;
        end
    end

    assign sam_clk_en  = sam_q;
    assign sys_clk2_en = clk2_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Phase sequencer for the time-shared FIR multiplier: per sample strobe it steps
// NPH coefficient phases, then loads the output register, with sticky overrun.
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned DIV      = DefaultDiv,
    parameter int unsigned NPH      = DefaultNph,
    parameter int unsigned PH_W     = DefaultPhW,
    parameter bit          EXT_SYNC = 1'b0
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            run,
    input  logic            ext_strobe,
    input  logic            ovr_clr,
    output logic            sam_clk_en,
    output logic            sys_clk2_en,
    output logic [PH_W-1:0] phase,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            y_load,
    output logic            busy,
    output logic            overrun
);

    if ((DIV < NPH + 2) || ((2 ** PH_W) < NPH)) begin : gen_param_check
        $fatal(1, "fir_mac_sequencer: need DIV >= NPH+2 and 2**PH_W >= NPH");
    end

    localparam logic [PH_W-1:0] PhLast = PH_W'(NPH - 1);

    seq_state_e      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            acc_clr_q, acc_clr_d;
    logic            acc_en_q, acc_en_d;
    logic            y_load_q, y_load_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            gen_en;
    logic            gen_start;

    assign gen_en    = run && (state_q != StIdle);
    assign gen_start = run && (state_q == StIdle);

    sample_strobe_gen #(
        .DIV      (DIV),
        .EXT_SYNC (EXT_SYNC)
    ) u_strobe (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .start       (gen_start),
        .en          (gen_en),
        .ext_strobe  (ext_strobe),
        .sam_clk_en  (sam_clk_en),
        .sys_clk2_en (sys_clk2_en)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Dropping run aborts any sample in flight; no y_load is issued for it.
    always_comb begin
        state_d = state_q;
        phase_d = '0;
        if (!run) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: state_d = StWait;
                StWait: begin
                    if (sam_clk_en) begin
                        state_d = StMac;
                    end
                end
                StMac: begin
                    if (phase_q == PhLast) begin
                        state_d = StDump;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                StDump: state_d = StWait;
                default: state_d = StIdle;
            endcase
        end
    end

    // Strobes are decoded from the next state so the datapath sees flop outputs.
    always_comb begin
        acc_en_d  = (state_d == StMac);
        acc_clr_d = (state_d == StMac) && (phase_d == '0);
        y_load_d  = (state_d == StDump);
        busy_d    = (state_d == StMac) || (state_d == StDump);
        overrun_d = overrun_q;
        if (sam_clk_en && busy_q) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            acc_clr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            y_load_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_clr_q <= acc_clr_d;
            acc_en_q  <= acc_en_d;
            y_load_q  <= y_load_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign phase   = phase_q;
    assign acc_clr = acc_clr_q;
    assign acc_en  = acc_en_q;
    assign y_load  = y_load_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Timing and phase controller for the time-shared multiplier in the polyphase FIR datapath. Derives the sample-rate enable and half-rate enable from `sys_clk`. On every sample it runs the shared multiplier through `NPH` coefficient phases, issuing the accumulator clear/enable and output-load strobes the datapath needs. It sits between the clock-enable generation and the FIR filter and replaces the free-running 2-bit phase counter with a sample-aligned, restartable sequence.

## Interface
- `DIV`, 8, `sys_clk` cycles per sample in internal mode; must be ≥ `NPH`+2.
- `NPH`, 4, multiplier phases per sample (one `sum_lvl_1` term per phase).
- `PH_W`, 2, width of `phase`; must satisfy 2^`PH_W` ≥ `NPH`.
- `EXT_SYNC`, 0, 1 = sample timing taken from `ext_strobe`; 0 = internal divider.

Ports:
- `sys_clk` in 1: single clock for the block; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `run` in 1: level; 1 = sequencer active, 0 = return to IDLE.
- `ext_strobe` in 1: external one-cycle sample strobe; ignored when `EXT_SYNC`=0.
- `ovr_clr` in 1: one-cycle pulse that clears `overrun`.
- `sam_clk_en` out 1: one-cycle sample strobe, registered.
- `sys_clk2_en` out 1: half-rate enable, registered.
- `phase` out `PH_W`: coefficient/operand select for the multiplier muxes.
- `acc_clr` out 1: load accumulator with product (first phase).
- `acc_en` out 1: accumulate product this cycle.
- `y_load` out 1: register accumulator into `y`.
- `busy` out 1: high in MAC or DUMP.
- `overrun` out 1: sticky; a sample strobe arrived while busy.

## Operation
- States: IDLE, WAIT, MAC, DUMP.
- IDLE
  - Divider counter, `phase`, and all strobes held at 0.
  - `run`=1 → WAIT on the next cycle.
- WAIT
  - Internal mode: the divider counter `div_cnt` counts 0..`DIV`-1 and wraps. `sam_clk_en`=1 for the cycle after `div_cnt`=`DIV`-1.
  - External mode: `sam_clk_en` = `ext_strobe` delayed one cycle.
  - `sam_clk_en`=1 → MAC, with `phase`=0.
- MAC
  - One phase per cycle; `phase` runs 0..`NPH`-1.
  - `acc_en`=1 on every MAC cycle; `acc_clr`=1 only when `phase`=0.
  - After `phase`=`NPH`-1 → DUMP.
- DUMP
  - `y_load`=1 for exactly one cycle, then → WAIT.
  - `phase` returns to 0.
- `sys_clk2_en`
  - Toggles every cycle while `run`=1, starting at 1 in the first WAIT cycle.
  - 0 in IDLE.
  - Independent of the FSM state.
- Sample strobe while `busy`=1
  - The strobe is still output on `sam_clk_en` but does not restart the sequence.
  - The current sample completes.
  - `overrun` is set to 1 on the next cycle.
  - Only possible in external mode.
- `overrun` clear and set in the same cycle: set wins.
- `run`=0 in any state
  - Next cycle: IDLE.
  - The MAC in progress is aborted and no `y_load` is issued.
  - `overrun` is retained.
- `reset` mid-sequence
  - Immediate IDLE; all outputs 0, including `overrun`.
- Phase width: `phase` never exceeds `NPH`-1; unused codes never appear.

## Timing
- Reset values: every output is 0.
- Internal mode
  - First `sam_clk_en` arrives `DIV` cycles after the first WAIT cycle.
  - Thereafter `sam_clk_en` has period `DIV`.
- Sample latency, with `sam_clk_en` high at cycle t:
  - MAC phases at t+1..t+`NPH`.
  - `y_load` at t+`NPH`+1.
  - WAIT from t+`NPH`+2.
- With defaults, `busy` is high for 5 of every 8 cycles.
- Datapath contract: `phase` and `acc_*` are registered outputs, valid for the whole cycle. The product for `phase`=k is available combinationally in the same cycle.
- Elaboration check: `DIV` < `NPH`+2, or 2^`PH_W` < `NPH`, is a fatal elaboration error.

## Structure
- Shared package `fir_ctrl_pkg`:
  - FSM state enum (IDLE/WAIT/MAC/DUMP).
  - Default `NPH`/`DIV` constants, reused by the FIR datapath.
- Sub-module `sample_strobe_gen`: divider counter plus external-strobe delay register. Outputs `sam_clk_en` and `sys_clk2_en`.
- The FSM, phase counter and overrun flag stay in the top level.

## Test plan
- Reset then `run`=1, internal mode, defaults:
  - `sam_clk_en` first at cycle 8 after WAIT, then every 8 cycles.
  - `phase` 0,1,2,3 with `acc_clr` only on 0.
  - `y_load` 5 cycles after `sam_clk_en`.
  - `overrun` stays 0.
- `sys_clk2_en` check: after `run`=1 it reads 1,0,1,0… continuously across MAC/DUMP boundaries; 0 in IDLE.
- `EXT_SYNC`=1, `ext_strobe` pulses 3 cycles apart:
  - Second strobe lands during MAC.
  - The sequence completes once, with one `y_load`.
  - `overrun`=1 from the next cycle.
  - `ovr_clr` then returns it to 0.
- Drop `run` at `phase`=2:
  - Next cycle: IDLE, `phase`=0, `acc_en`=0.
  - No `y_load` for that sample.
  - Re-assert `run`: a clean sequence restarts from WAIT.
- Assert `reset` asynchronously mid-MAC with `overrun`=1: all outputs 0 immediately, before the next clock edge.
- `ovr_clr` and an overrunning strobe in the same cycle: `overrun` reads 1.
